// File: rtl/hopfield_tdm_array.sv
// hopfield_tdm_array: time-multiplexed leaky integrate-and-fire Hopfield array.
// A single update unit scans the N neurons, one per cycle. Each neuron sums an
// external drive with recurrent current from the N x N signed weight matrix,
// gated by the spike vector committed at the end of the previous sweep.
// Build option: define HOPFIELD_HEBB_EN to add the Hebbian LEARN pass.
// Handshake: run is a level enable, sampled in IDLE and at the end of every
// sweep/LEARN pass; spikes_valid is a one-cycle pulse with no back-pressure,
// and spikes holds its value between pulses.
module hopfield_tdm_array #(
  parameter int N          = 8,
  parameter int VW         = 16,
  parameter int WW         = 12,
  parameter int THRESH     = 1024,
  parameter int EXT_GAIN   = 1024,
  parameter int LEAK_SHIFT = 4,
  parameter int AW         = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [N-1:0]         ext_in,
  input  logic                 learn,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_row,
  input  logic [AW-1:0]        w_col,
  input  logic signed [WW-1:0] w_data,
  output logic [N-1:0]         spikes,
  output logic                 spikes_valid,
  output logic                 busy
);

  localparam int SW = VW + AW;      // current accumulator width
  localparam int XW = VW + AW + 2;  // common width ahead of saturation
  localparam logic signed [VW-1:0] THRESH_V = VW'(THRESH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_LEARN = 2'd2;

  // state is kept as a plain named register so checkers can bind to it
  logic [1:0]           state;
  logic [AW-1:0]        idx;
  logic [N-1:0]         nxt;
  logic signed [VW-1:0] v [N];
  logic signed [WW-1:0] w [N][N];

  logic signed [SW-1:0] i_sum;
  logic signed [VW-1:0] i_sat;
  logic signed [VW-1:0] v_cur;
  logic signed [XW-1:0] v_sum;
  logic signed [VW-1:0] v_new;
  logic                 fire;
  logic                 last;
  logic [N-1:0]         nxt_vec;
  logic                 w_ok;

  function automatic logic signed [VW-1:0] sat_vw(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = {{(XW-VW+1){1'b0}}, {(VW-1){1'b1}}};
    lo = {{(XW-VW+1){1'b1}}, {(VW-1){1'b0}}};
    if (x > hi) return hi[VW-1:0];
    if (x < lo) return lo[VW-1:0];
    return x[VW-1:0];
  endfunction

`ifdef HOPFIELD_HEBB_EN
  // +1 when both neurons spiked, -1 when exactly one did, saturating at WW
  function automatic logic signed [WW-1:0] hebb(input logic signed [WW-1:0] cur,
                                                input logic a, input logic b);
    logic signed [WW:0] t;
    t = {cur[WW-1], cur};
    if (a && b)      t = t + (WW+1)'(1);
    else if (a ^ b)  t = t - (WW+1)'(1);
    if (t[WW] != t[WW-1]) return t[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    return t[WW-1:0];
  endfunction
`else
  logic unused_learn;
  assign unused_learn = learn;
`endif

  // input current for the neuron under scan, from committed spikes only
  always_comb begin
    i_sum = ext_in[idx] ? SW'(EXT_GAIN) : '0;
    for (int j = 0; j < N; j++) begin
      if (AW'(j) != idx && spikes[j]) i_sum = i_sum + SW'(w[j][idx]);
    end
  end

  // leaky integrate for the neuron under scan and the threshold decision
  always_comb begin
    i_sat   = sat_vw(XW'(i_sum));
    v_cur   = v[idx];
    v_sum   = XW'(v_cur) - XW'(v_cur >>> LEAK_SHIFT) + XW'(i_sat);
    v_new   = sat_vw(v_sum);
    fire    = (v_new >= THRESH_V);
    nxt_vec = nxt;
    nxt_vec[idx] = fire;
    last    = (idx == AW'(N - 1));
    w_ok    = w_we && (w_row != w_col) &&
              ({1'b0, w_row} < (AW+1)'(N)) && ({1'b0, w_col} < (AW+1)'(N));
  end

  assign busy = (state != S_IDLE);

  // sequencer, membrane store, weight store and spike commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      nxt          <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        v[i] <= '0;
        for (int j = 0; j < N; j++) w[i][j] <= '0;
      end
    end else begin
      spikes_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (w_ok) w[w_row][w_col] <= w_data;
          if (run) begin
            state <= S_SCAN;
            idx   <= '0;
          end
        end
        S_SCAN: begin
          v[idx] <= fire ? '0 : v_new;
          nxt    <= nxt_vec;
          if (last) begin
            spikes       <= nxt_vec;
            spikes_valid <= 1'b1;
            idx          <= '0;
`ifdef HOPFIELD_HEBB_EN
            if (learn)    state <= S_LEARN;
            else if (run) state <= S_SCAN;
            else          state <= S_IDLE;
`else
            state <= run ? S_SCAN : S_IDLE;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef HOPFIELD_HEBB_EN
        S_LEARN: begin
          for (int j = 0; j < N; j++) begin
            if (AW'(j) != idx) w[idx][j] <= hebb(w[idx][j], spikes[idx], spikes[j]);
          end
          if (last) begin
            idx   <= '0;
            state <= run ? S_SCAN : S_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hopfield_tdm_array.sv
// tb_hopfield_tdm_array: randomized bench for hopfield_tdm_array with a
// sweep-level reference model and a queue-based scoreboard.
module tb_hopfield_tdm_array;

  localparam int N          = 8;
  localparam int VW         = 16;
  localparam int WW         = 12;
  localparam int THRESH     = 1024;
  localparam int EXT_GAIN   = 1024;
  localparam int LEAK_SHIFT = 4;
  localparam int AW         = 3;

  logic                 clk;
  logic                 reset_n;
  logic                 run;
  logic [N-1:0]         ext_in;
  logic                 learn;
  logic                 w_we;
  logic [AW-1:0]        w_row;
  logic [AW-1:0]        w_col;
  logic signed [WW-1:0] w_data;
  logic [N-1:0]         spikes;
  logic                 spikes_valid;
  logic                 busy;

  hopfield_tdm_array #(
    .N(N), .VW(VW), .WW(WW), .THRESH(THRESH), .EXT_GAIN(EXT_GAIN),
    .LEAK_SHIFT(LEAK_SHIFT), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ext_in(ext_in), .learn(learn),
    .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .spikes(spikes), .spikes_valid(spikes_valid), .busy(busy)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int           mv [N];
  int           mw [N][N];
  logic [N-1:0] mspk;

  // scoreboard
  logic [N-1:0] exp_q[$];
  int           exp_t_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic int clampi(int x, int lo, int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      for (int j = 0; j < N; j++) mw[i][j] = 0;
    end
    mspk = '0;
  endtask

  // one complete sweep given the ext bit seen by each neuron in its scan cycle
  task automatic model_sweep(input logic [N-1:0] ext, output logic [N-1:0] res);
    int cur, vn;
    res = '0;
    for (int i = 0; i < N; i++) begin
      cur = ext[i] ? EXT_GAIN : 0;
      for (int j = 0; j < N; j++) if (j != i && mspk[j]) cur += mw[j][i];
      cur = clampi(cur, -32768, 32767);
      vn  = clampi(mv[i] - (mv[i] >>> LEAK_SHIFT) + cur, -32768, 32767);
      if (vn >= THRESH) begin
        res[i] = 1'b1;
        mv[i]  = 0;
      end else begin
        mv[i] = vn;
      end
    end
    mspk = res;
  endtask

  task automatic model_learn();
    int d;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        if (j != r) begin
          d = (mspk[r] && mspk[j]) ? 1 : ((mspk[r] != mspk[j]) ? -1 : 0);
          mw[r][j] = clampi(mw[r][j] + d, -2048, 2047);
        end
  endtask

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0; ext_in = '0; learn = 1'b0; w_we = 1'b0;
    w_row = '0; w_col = '0; w_data = '0;
    model_clear();
    exp_q.delete();
    exp_t_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write_w(input int r, input int c, input int d);
    @(negedge clk);
    w_we = 1'b1; w_row = AW'(r); w_col = AW'(c); w_data = WW'(d);
    if (r != c) mw[r][c] = d;
    @(posedge clk);
    #1 w_we = 1'b0;
  endtask

  task automatic random_write_attempt();
    w_we   = ($urandom_range(0, 2) == 0);
    w_row  = AW'($urandom_range(0, N - 1));
    w_col  = AW'($urandom_range(0, N - 1));
    w_data = WW'($urandom);
  endtask

  // fixed_ext < 0 means random ext_in every cycle; the last sweep drops run
  task automatic run_sweeps(input int nsw, input int fixed_ext, input int lrn_mode);
    logic [N-1:0] ext_rec;
    logic [N-1:0] res;
    logic         lrn;
    int           drop;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    for (int s = 0; s < nsw; s++) begin
      lrn  = (lrn_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(lrn_mode);
      drop = $urandom_range(0, N - 1);
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        if (s == 0 && c == 0) chk("busy_after_run", int'(busy), 1);
        ext_in = (fixed_ext >= 0) ? N'(fixed_ext) : N'($urandom);
        ext_rec[c] = ext_in[c];
        learn = lrn;
        random_write_attempt();
        if (s == nsw - 1 && c == drop) run = 1'b0;
        if (c == N - 1) begin
          model_sweep(ext_rec, res);
          exp_q.push_back(res);
          exp_t_q.push_back(cyc + 1);
        end
        @(posedge clk);
      end
`ifdef HOPFIELD_HEBB_EN
      if (lrn) begin
        model_learn();
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          random_write_attempt();
          @(posedge clk);
        end
      end
`endif
    end
    @(negedge clk);
    w_we  = 1'b0;
    learn = 1'b0;
    chk("busy_idle_after_sweeps", int'(busy), 0);
  endtask

  task automatic check_weights(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk({"weight_", tag}, int'(dut.w[r][c]), mw[r][c]);
  endtask

  // monitor: pops the scoreboard on every pulse, checks holding otherwise
  task automatic monitor_loop();
    logic [N-1:0] held;
    logic [N-1:0] e;
    int           t;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = '0;
      end else if (spikes_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'(spikes), -1);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          chk("spikes", int'(spikes), int'(e));
          chk("pulse_cycle", cyc, t);
          held = e;
        end
      end else begin
        chk("spikes_hold", int'(spikes), int'(held));
      end
    end
  endtask

  initial begin
    int nw;
    fork
      monitor_loop();
      begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_spikes", int'(spikes), 0);
    chk("reset_valid", int'(spikes_valid), 0);
    chk("reset_busy", int'(busy), 0);
    check_weights("reset");

    // constant drive, zero weights
    run_sweeps(3, 'h05, 0);

    // recurrent excitation, diagonal write ignored
    do_reset();
    write_w(0, 1, 1024);
    write_w(2, 2, 500);
    check_weights("directed_write");
    run_sweeps(2, 'h01, 0);
    check_weights("after_busy_writes");

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_spikes", int'(spikes), 0);
    chk("midreset_valid", int'(spikes_valid), 0);
    chk("midreset_busy", int'(busy), 0);
    run = 1'b0;
    model_clear();
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check_weights("midreset");
    run_sweeps(2, -1, 0);

    // learn request with a saturating weight
    do_reset();
    write_w(0, 1, 2047);
    run_sweeps(2, 'h03, 1);
    check_weights("learn");

    // randomized rounds
    for (int rnd = 0; rnd < 40; rnd++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      nw = $urandom_range(0, 10);
      for (int k = 0; k < nw; k++) begin
        int val;
        case ($urandom_range(0, 9))
          0:       val = 2047;
          1:       val = -2048;
          default: val = int'($urandom_range(0, 1200)) - 600;
        endcase
        write_w($urandom_range(0, N - 1), $urandom_range(0, N - 1), val);
      end
      run_sweeps($urandom_range(1, 6), -1, 2);
      check_weights("random");
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
